ip_codma_burst_wr_engine: RTL and testbench

IP_CODMA_BURST_WR_ENGINE -- requirements
Module: ip_codma_burst_wr_engine

---
 rtl/ip_codma_states_pkg.sv | 16 +
 rtl/ip_codma_burst_wr_engine.sv | 175 +++++++++++++++++
 tb/tb_ip_codma_burst_wr_engine.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_codma_states_pkg.sv
// Shared state encoding and beat-size helper for the CODMA write engine.
package ip_codma_states_pkg;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_ASK     = 3'd1,
    WR_GRANTED = 3'd2,
    WR_DONE    = 3'd3,
    WR_ERROR   = 3'd4
  } write_state_t;

  function automatic int unsigned WR_BEAT_BYTES(input int unsigned data_w);
    return data_w / 32'd8;
  endfunction

endpackage

// File: rtl/ip_codma_burst_wr_engine.sv
// Burst write engine: arbitrates for the bus, streams read-side data as
// incrementing-address write beats and reports completion or error.
module ip_codma_burst_wr_engine
  import ip_codma_states_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 16,
  localparam int LEN_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_ready_o,
  output logic              bus_req_o,
  input  logic              bus_grant_i,
  output logic              bus_write_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic              bus_error_i,
  input  logic              stop_i,
  output logic              done_o,
  output logic              error_o,
  output logic [LEN_W-1:0]  beats_left_o,
  output write_state_t      wr_state_o
);

  localparam logic [ADDR_W-1:0] BEAT_INC = ADDR_W'(WR_BEAT_BYTES(DATA_W));
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BEATS);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  write_state_t      state_r;
  write_state_t      state_nxt_s;
  logic              illegal_s;
  logic              accept_s;
  logic              len_ok_s;
  logic              beat_s;
  logic              last_beat_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  beats_left_r;
  logic              done_r;
  logic              error_r;

  // Stop and bus error both suppress the beat so neither advances the counters.
  assign accept_s    = (state_r == WR_IDLE) && req_valid_i && !stop_i;
  assign len_ok_s    = (req_len_i != '0) && (req_len_i <= LEN_MAX);
  assign beat_s      = (state_r == WR_GRANTED) && data_valid_i && bus_ready_i
                       && !stop_i && !bus_error_i;
  assign last_beat_s = beat_s && (beats_left_r == LEN_ONE);

  // Next-state decode; stop overrides everything, then error, last beat, grant loss.
  always_comb begin
    state_nxt_s = state_r;
    illegal_s   = 1'b0;
    if (stop_i) begin
      state_nxt_s = WR_IDLE;
    end else begin
      case (state_r)
        WR_IDLE: begin
          if (req_valid_i) begin
            if (len_ok_s) begin
              state_nxt_s = WR_ASK;
            end else begin
              state_nxt_s = WR_ERROR;
            end
          end else begin
            state_nxt_s = WR_IDLE;
          end
        end
        WR_ASK: begin
          if (bus_error_i) begin
            state_nxt_s = WR_ERROR;
          end else if (bus_grant_i) begin
            state_nxt_s = WR_GRANTED;
          end else begin
            state_nxt_s = WR_ASK;
          end
        end
        WR_GRANTED: begin
          if (bus_error_i) begin
            state_nxt_s = WR_ERROR;
          end else if (last_beat_s) begin
            state_nxt_s = WR_DONE;
          end else if (!bus_grant_i && !beat_s) begin
            state_nxt_s = WR_ASK;
          end else begin
            state_nxt_s = WR_GRANTED;
          end
        end
        WR_DONE:  state_nxt_s = WR_IDLE;
        WR_ERROR: state_nxt_s = WR_IDLE;
        default: begin
          state_nxt_s = WR_IDLE;
          illegal_s   = 1'b1;
        end
      endcase
    end
  end

  // Bus-side outputs decoded from the state; write data passes straight through.
  always_comb begin
    req_ready_o  = 1'b0;
    bus_req_o    = 1'b0;
    bus_write_o  = 1'b0;
    bus_wdata_o  = '0;
    data_ready_o = 1'b0;
    case (state_r)
      WR_IDLE: begin
        req_ready_o = 1'b1;
      end
      WR_ASK: begin
        bus_req_o = 1'b1;
      end
      WR_GRANTED: begin
        bus_req_o    = 1'b1;
        bus_write_o  = data_valid_i;
        bus_wdata_o  = data_i;
        data_ready_o = bus_ready_i;
      end
      default: begin
        req_ready_o = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= WR_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Completion and error pulses, coincident with the WR_DONE / WR_ERROR cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      done_r  <= (state_nxt_s == WR_DONE);
      error_r <= (state_nxt_s == WR_ERROR) || illegal_s;
    end
  end

  // Address generator and beat counter; the address wraps silently.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_r       <= '0;
      beats_left_r <= '0;
    end else if (accept_s && len_ok_s) begin
      addr_r       <= req_addr_i;
      beats_left_r <= req_len_i;
    end else if (beat_s) begin
      addr_r       <= addr_r + BEAT_INC;
      beats_left_r <= beats_left_r - LEN_ONE;
    end else begin
      addr_r       <= addr_r;
      beats_left_r <= beats_left_r;
    end
  end

  assign bus_addr_o   = addr_r;
  assign beats_left_o = beats_left_r;
  assign done_o       = done_r;
  assign error_o      = error_r;
  assign wr_state_o   = state_r;

endmodule

// File: tb/tb_ip_codma_burst_wr_engine.sv
// Directed self-checking bench for the CODMA burst write engine.
module tb_ip_codma_burst_wr_engine;
  import ip_codma_states_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = $clog2(MAX_BEATS + 1);

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [LEN_W-1:0]  req_len_i;
  logic              data_valid_i;
  logic [DATA_W-1:0] data_i;
  logic              data_ready_o;
  logic              bus_req_o;
  logic              bus_grant_i;
  logic              bus_write_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ready_i;
  logic              bus_error_i;
  logic              stop_i;
  logic              done_o;
  logic              error_o;
  logic [LEN_W-1:0]  beats_left_o;
  write_state_t      wr_state_o;

  int checks = 0;
  int errors = 0;

  ip_codma_burst_wr_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .bus_req_o(bus_req_o), .bus_grant_i(bus_grant_i), .bus_write_o(bus_write_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ready_i(bus_ready_i), .bus_error_i(bus_error_i),
    .stop_i(stop_i), .done_o(done_o), .error_o(error_o),
    .beats_left_o(beats_left_o), .wr_state_o(wr_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_req(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    req_addr_i  = addr;
    req_len_i   = len;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic chk_pulses(input string tag, input logic exp_done, input logic exp_err);
    chk({tag, "_done"}, 64'(done_o), 64'(exp_done));
    chk({tag, "_err"}, 64'(error_o), 64'(exp_err));
  endtask

  initial begin
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_len_i    = '0;
    data_valid_i = 1'b0;
    data_i       = '0;
    bus_grant_i  = 1'b0;
    bus_ready_i  = 1'b0;
    bus_error_i  = 1'b0;
    stop_i       = 1'b0;

    // Reset values.
    #3;
    chk("rst_state", 64'(wr_state_o), 64'(WR_IDLE));
    chk("rst_rdy", 64'(req_ready_o), 64'd1);
    chk("rst_breq", 64'(bus_req_o), 64'd0);
    chk("rst_addr", 64'(bus_addr_o), 64'd0);
    chk("rst_beats", 64'(beats_left_o), 64'd0);
    chk_pulses("rst", 1'b0, 1'b0);
    tick();
    tick();
    reset_i = 1'b0;

    // Normal burst: 0x1000, 4 beats.
    bus_grant_i  = 1'b1;
    bus_ready_i  = 1'b1;
    data_valid_i = 1'b1;
    start_req(32'h0000_1000, 5'd4);
    chk("n_ask", 64'(wr_state_o), 64'(WR_ASK));
    chk("n_ask_breq", 64'(bus_req_o), 64'd1);
    chk("n_ask_drdy", 64'(data_ready_o), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      data_i = 32'hA500_0000 | 32'(i);
      #1;
      chk("n_state", 64'(wr_state_o), 64'(WR_GRANTED));
      chk("n_addr", 64'(bus_addr_o), 64'h1000 + 64'(4 * i));
      chk("n_beats", 64'(beats_left_o), 64'(4 - i));
      chk("n_wdata", 64'(bus_wdata_o), 64'h0000_0000_A500_0000 | 64'(i));
      chk("n_write", 64'(bus_write_o), 64'd1);
      chk("n_drdy", 64'(data_ready_o), 64'd1);
      tick();
    end
    chk("n_done_st", 64'(wr_state_o), 64'(WR_DONE));
    chk_pulses("n_done", 1'b1, 1'b0);
    chk("n_done_breq", 64'(bus_req_o), 64'd0);
    tick();
    chk("n_idle", 64'(wr_state_o), 64'(WR_IDLE));
    chk_pulses("n_idle", 1'b0, 1'b0);
    chk("n_idle_rdy", 64'(req_ready_o), 64'd1);

    // Grant loss after beat 3 of 8.
    start_req(32'h0000_2000, 5'd8);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("g_addr", 64'(bus_addr_o), 64'h2000 + 64'(4 * i));
      tick();
    end
    bus_grant_i  = 1'b0;
    data_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("g_ask", 64'(wr_state_o), 64'(WR_ASK));
      chk("g_beats", 64'(beats_left_o), 64'd5);
      chk("g_addr_hold", 64'(bus_addr_o), 64'h200C);
      chk("g_drdy", 64'(data_ready_o), 64'd0);
    end
    bus_grant_i  = 1'b1;
    data_valid_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("g_res_st", 64'(wr_state_o), 64'(WR_GRANTED));
      chk("g_res_addr", 64'(bus_addr_o), 64'h200C + 64'(4 * i));
      chk("g_res_beats", 64'(beats_left_o), 64'(5 - i));
      tick();
    end
    chk("g_done_st", 64'(wr_state_o), 64'(WR_DONE));
    chk_pulses("g_done", 1'b1, 1'b0);
    tick();
    chk("g_idle", 64'(wr_state_o), 64'(WR_IDLE));

    // Bus error on beat 2 of 4.
    start_req(32'h0000_3000, 5'd4);
    tick();
    tick();
    chk("e_b1_addr", 64'(bus_addr_o), 64'h3004);
    bus_error_i = 1'b1;
    tick();
    bus_error_i = 1'b0;
    chk("e_state", 64'(wr_state_o), 64'(WR_ERROR));
    chk_pulses("e_err", 1'b0, 1'b1);
    chk("e_beats", 64'(beats_left_o), 64'd3);
    chk("e_addr", 64'(bus_addr_o), 64'h3004);
    tick();
    chk("e_idle", 64'(wr_state_o), 64'(WR_IDLE));
    chk_pulses("e_idle", 1'b0, 1'b0);

    // Stop and bus error together.
    start_req(32'h0000_4000, 5'd4);
    tick();
    chk("s_gr", 64'(wr_state_o), 64'(WR_GRANTED));
    stop_i      = 1'b1;
    bus_error_i = 1'b1;
    tick();
    stop_i      = 1'b0;
    bus_error_i = 1'b0;
    chk("s_idle", 64'(wr_state_o), 64'(WR_IDLE));
    chk_pulses("s_idle", 1'b0, 1'b0);
    chk("s_rdy", 64'(req_ready_o), 64'd1);
    tick();
    chk_pulses("s_after", 1'b0, 1'b0);

    // Bad lengths: 0 and MAX_BEATS+1.
    start_req(32'h0000_5000, 5'd0);
    chk("l0_state", 64'(wr_state_o), 64'(WR_ERROR));
    chk("l0_breq", 64'(bus_req_o), 64'd0);
    chk_pulses("l0", 1'b0, 1'b1);
    tick();
    chk("l0_idle", 64'(wr_state_o), 64'(WR_IDLE));
    start_req(32'h0000_5000, 5'd17);
    chk("l17_state", 64'(wr_state_o), 64'(WR_ERROR));
    chk("l17_breq", 64'(bus_req_o), 64'd0);
    chk_pulses("l17", 1'b0, 1'b1);
    tick();
    chk("l17_breq2", 64'(bus_req_o), 64'd0);

    // Address wrap-around.
    start_req(32'hFFFF_FFFC, 5'd2);
    tick();
    chk("w_addr0", 64'(bus_addr_o), 64'hFFFF_FFFC);
    tick();
    chk("w_addr1", 64'(bus_addr_o), 64'h0000_0000);
    chk("w_beats1", 64'(beats_left_o), 64'd1);
    tick();
    chk("w_done_st", 64'(wr_state_o), 64'(WR_DONE));
    chk_pulses("w_done", 1'b1, 1'b0);
    tick();

    // Reset mid-burst.
    start_req(32'h0000_6000, 5'd4);
    tick();
    tick();
    data_i = 32'hDEAD_BEEF;
    chk("r_pre_st", 64'(wr_state_o), 64'(WR_GRANTED));
    #2;
    reset_i = 1'b1;
    #1;
    chk("r_state", 64'(wr_state_o), 64'(WR_IDLE));
    chk("r_rdy", 64'(req_ready_o), 64'd1);
    chk("r_breq", 64'(bus_req_o), 64'd0);
    chk("r_write", 64'(bus_write_o), 64'd0);
    chk("r_drdy", 64'(data_ready_o), 64'd0);
    chk("r_addr", 64'(bus_addr_o), 64'd0);
    chk("r_wdata", 64'(bus_wdata_o), 64'd0);
    chk("r_beats", 64'(beats_left_o), 64'd0);
    chk_pulses("r", 1'b0, 1'b0);
    tick();
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r_post_st", 64'(wr_state_o), 64'(WR_IDLE));
      chk("r_post_rdy", 64'(req_ready_o), 64'd1);
      chk_pulses("r_post", 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
